// File: rtl/divider.sv
// Multi-cycle 32/32 restoring divider with a signed-dividend option and floored correction.
// The step counter s is the only control state: operands are loaded at s=0, steps run for s=1..32, and results hold at s=33.
module divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        run,
   input  logic        u,
   output logic        stall,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic [31:0] quot,
   output logic [31:0] rem
);

   localparam logic [5:0] last_step = 6'd33;

   logic [5:0]  s;
   logic [63:0] acc;     // {partial remainder, dividend/quotient bits}
   logic [31:0] yr;
   logic        neg;
   logic [33:0] diff;
   logic [31:0] q;
   logic [31:0] r;

   // Trial subtraction on the upper 33 bits of the left-shifted register; diff[33] is the borrow.
   assign diff = {1'b0, acc[63:31]} - {2'b00, yr};

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s   <= 6'd0;
         acc <= 64'd0;
         yr  <= 32'd0;
         neg <= 1'b0;
      end else if (enable) begin
         if (!run)
            s <= 6'd0;
         else if (s != last_step)
            s <= s + 6'd1;

         if (s == 6'd0) begin
            acc <= {32'd0, (u && x[31]) ? -x : x};
            yr  <= y;
            neg <= u & x[31];
         end else if (s <= 6'd32) begin
            if (!diff[33])
               acc <= {diff[31:0], acc[30:0], 1'b1};
            else
               acc <= {acc[62:0], 1'b0};
         end
      end
   end

   assign stall = run && (s != last_step);
   assign q     = acc[31:0];
   assign r     = acc[63:32];

   // NOTE: defaults first so every path assigns every output and no latch is inferred.
   always_comb begin
      quot = q;
      rem  = r;
      if (neg) begin
         if (r == 32'd0) begin
            quot = -q;
            rem  = 32'd0;
         end else begin
            // Floored result: -q-1 with the remainder folded back into [0, y).
            quot = ~q;
            rem  = yr - r;
         end
      end
   end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: drivers queue hand-computed results, a negedge monitor checks each completed division.
module tb_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        run;
   logic        u;
   logic        stall;
   logic [31:0] x;
   logic [31:0] y;
   logic [31:0] quot;
   logic [31:0] rem;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   checks    = 0;
   int   failures  = 0;
   int   done_cnt  = 0;
   int   stall_cnt = 0;

   divider dut (
      .clk(clk), .rst(rst), .enable(enable), .run(run), .u(u),
      .stall(stall), .x(x), .y(y), .quot(quot), .rem(rem)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: counts stall cycles of the current operation and checks results when stall falls with run high.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst || !run) begin
            stall_cnt = 0;
         end else if (stall) begin
            stall_cnt++;
         end else if (stall_cnt > 0) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result actual=%h/%h expected=none", quot, rem);
            end else begin
               e = sb.pop_front();
               check("quot", quot, e.q);
               check("rem", rem, e.r);
               check("stall_cycles", 32'(stall_cnt), 32'(e.cyc));
            end
            done_cnt++;
            stall_cnt = 0;
         end
      end
   end

   // Waits for the monitor to retire an operation, then checks that results hold for one more cycle at s=33.
   task automatic finish_op(input int start, input logic [31:0] eq, input logic [31:0] er);
      int guard = 0;
      while (done_cnt == start && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (done_cnt == start) begin
         checks++;
         failures++;
         $display("FAIL timeout actual=no_completion expected=completion");
      end
      @(posedge clk); #1;
      check("hold_quot", quot, eq);
      check("hold_rem", rem, er);
      check("hold_stall", {31'd0, stall}, 32'd0);
      run = 1'b0;
      @(posedge clk); #1;
   endtask

   // Issues one division; operands are scrambled after the load edge, optional 10-cycle enable freeze at step fs.
   task automatic run_op(input logic uu, input logic [31:0] xx, input logic [31:0] yy,
                         input logic [31:0] eq, input logic [31:0] er, input int fs);
      int start = done_cnt;
      sb.push_back('{eq, er, (fs > 0) ? 43 : 33});
      u = uu; x = xx; y = yy; run = 1'b1;
      @(posedge clk); #1;
      x = ~xx; y = yy + 32'd3; u = ~uu;
      if (fs > 0) begin
         repeat (fs - 1) begin @(posedge clk); #1; end
         enable = 1'b0;
         repeat (10) begin @(posedge clk); #1; end
         check("freeze_stall", {31'd0, stall}, 32'd1);
         enable = 1'b1;
      end
      finish_op(start, eq, er);
   endtask

   initial begin
      int start;
      rst = 1'b1; enable = 1'b1; run = 1'b0; u = 1'b0; x = 32'd0; y = 32'd0;
      #1;
      check("reset_stall_idle", {31'd0, stall}, 32'd0);
      check("reset_quot", quot, 32'd0);
      check("reset_rem", rem, 32'd0);
      run = 1'b1; #1;
      check("reset_stall_run", {31'd0, stall}, 32'd1);
      run = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(1'b0, 32'd100,        32'd7, 32'd14,         32'd2, 0);
      run_op(1'b1, 32'hFFFFFFF9,   32'd2, 32'hFFFFFFFC,   32'd1, 0);
      run_op(1'b1, 32'hFFFFFFF8,   32'd2, 32'hFFFFFFFC,   32'd0, 0);
      run_op(1'b0, 32'hFFFFFFF9,   32'd2, 32'h7FFFFFFC,   32'd1, 0);
      run_op(1'b0, 32'h00001234,   32'd0, 32'hFFFFFFFF,   32'h00001234, 0);
      run_op(1'b1, 32'hFFFFFFFB,   32'd0, 32'h00000000,   32'hFFFFFFFB, 0);
      run_op(1'b1, 32'd100,        32'd7, 32'd14,         32'd2, 0);
      run_op(1'b1, 32'h80000000,   32'd3, 32'hD5555555,   32'd1, 0);
      run_op(1'b0, 32'd123456,     32'd1000, 32'd123,     32'd456, 15);

      // Drop run at s=5: the partial division is abandoned and the next one starts clean.
      u = 1'b0; x = 32'hDEADBEEF; y = 32'd17; run = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      run = 1'b0;
      @(posedge clk); #1;
      check("abort_stall", {31'd0, stall}, 32'd0);
      run_op(1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 0);

      // Reset pulse at s=20, then a fresh division with run held high throughout.
      u = 1'b1; x = 32'hFFFF0000; y = 32'd9; run = 1'b1;
      repeat (20) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      check("midrst_stall", {31'd0, stall}, 32'd1);
      check("midrst_quot", quot, 32'd0);
      check("midrst_rem", rem, 32'd0);
      u = 1'b0; x = 32'd1000; y = 32'd10;
      start = done_cnt;
      sb.push_back('{32'd100, 32'd0, 33});
      @(posedge clk); #1;
      rst = 1'b0;
      finish_op(start, 32'd100, 32'd0);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port enable, input, 1 bit: clock enable; when low, all state holds.
REQ-004 SHALL have port run, input, 1 bit: held high by the core for the whole division.
REQ-005 SHALL have port u, input, 1 bit: 1 = signed dividend, 0 = unsigned.
REQ-006 SHALL have port stall, output, 1 bit: high while the division is in progress.
REQ-007 SHALL have port x, input, 32 bits: dividend.
REQ-008 SHALL have port y, input, 32 bits: divisor, always treated as unsigned.
REQ-009 SHALL have port quot, output, 32 bits: quotient.
REQ-010 SHALL have port rem, output, 32 bits: remainder.

Function
REQ-011 SHALL keep a 6-bit step counter S; when enable=1, S <= run ? S+1 : 0, saturating at 33 while run stays high.
REQ-012 SHALL drive stall = run AND (S != 33), combinationally.
REQ-013 SHALL, at S=0 with enable=1, capture |x| (when u=1 and x[31]=1), else x, into a 64-bit remainder/quotient register (upper 32 bits = 0), plus the divisor y and the sign flag neg = u AND x[31].
REQ-014 SHALL sample operands only at S=0; changes to x, y or u during S=1..33 SHALL have no effect.
REQ-015 SHALL perform one restoring step per enabled cycle for S=1..32: shift left 1; trial-subtract y from the upper 33 bits; on no borrow, keep the difference and set quotient bit 1, else restore and set quotient bit 0.
REQ-016 SHALL, at S=33, present results combinationally from the final register, with q = raw quotient and r = raw remainder.
REQ-017 SHALL, when neg=0, drive quot=q and rem=r.
REQ-018 SHALL, when neg=1 and r=0, drive quot=-q and rem=0.
REQ-019 SHALL, when neg=1 and r!=0, drive quot=-q-1 and rem=y-r (floored division, rem in [0, y)).
REQ-020 SHALL produce, for y=0, the restoring result with no trap: with neg=0, quot=0xFFFFFFFF and rem=x; with neg=1, quot=0 and rem=x.
REQ-021 SHALL, for a single operation with enable continuously high, raise stall in the first cycle run=1 and hold it high for exactly 33 cycles; the result is valid in the 34th cycle, when stall=0.
REQ-022 SHALL, when enable=0, freeze S and all registers; stall and results follow the frozen S.
REQ-023 SHALL, when run is dropped at any S, return S to 0 on the next enabled edge, abandoning any partial result.
REQ-024 SHALL, when run is high, S=33 and enable=1, keep quot and rem stable.
REQ-025 SHALL make quot and rem meaningful only at S=33; at other S they are undefined but deterministic.

Reset
REQ-026 SHALL, on rst=1, immediately clear S, the 64-bit register, the divisor register and neg to 0, independent of clk and enable.
REQ-027 SHALL hold stall = run while rst is asserted (S=0), and quot=0 and rem=0.
REQ-028 SHALL, when rst is asserted mid-division, abort the operation; after release with run high, restart from S=0 and load fresh operands.

Verification
REQ-029 SHALL cover: u=0, x=100, y=7 -> quot=14, rem=2; stall high exactly 33 cycles.
REQ-030 SHALL cover: u=1, x=0xFFFFFFF9 (-7), y=2 -> quot=0xFFFFFFFC (-4), rem=1; and u=1, x=-8, y=2 -> quot=-4, rem=0.
REQ-031 SHALL cover: u=0, x=0xFFFFFFF9, y=2 -> quot=0x7FFFFFFC, rem=1.
REQ-032 SHALL cover: y=0, u=0, x=0x1234 -> quot=0xFFFFFFFF, rem=0x1234; y=0, u=1, x=-5 -> quot=0, rem=0xFFFFFFFB.
REQ-033 SHALL cover: enable low for 10 cycles at S=15 -> S and stall frozen; completion delayed by exactly 10 cycles with unchanged result.
REQ-034 SHALL cover: rst pulse at S=20, then x=1000, y=10 -> S=0, stall restarts for 33 cycles, quot=100, rem=0.
